// File: rtl/moore_pattern_tx.sv
// Serial pattern transmitter: latches a WIDTH-bit pattern on start and shifts it out MSB-first,
// repeated repeat_cnt+1 times back-to-back, followed by a one-cycle done pulse.
module moore_pattern_tx #(
  parameter int   WIDTH    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             x_d, x_valid_d, busy_d, done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    case (state_q)
      S_IDLE: begin
        // abort takes priority over a simultaneous start
        if (start && !abort) begin
          pat_d   = pattern;
          shreg_d = pattern;
          rep_d   = repeat_cnt;
          idx_d   = LAST_IDX;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
          shreg_d = '0;
          idx_d   = '0;
          rep_d   = '0;
        end else if (idx_q == '0) begin
          if (rep_q != '0) begin
            // reload from the private copy so live input changes cannot leak in
            shreg_d = pat_q;
            rep_d   = rep_q - 1'b1;
            idx_d   = LAST_IDX;
          end else begin
            shreg_d = '0;
            state_d = S_DONE;
          end
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          idx_d   = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        idx_d   = '0;
        rep_d   = '0;
      end
    endcase

    // outputs are decoded from the next register values so they launch from flops
    x_d       = (state_d == S_SHIFT) ? shreg_d[WIDTH-1] : IDLE_BIT;
    x_valid_d = (state_d == S_SHIFT);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      x       <= x_d;
      x_valid <= x_valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_moore_pattern_tx.sv
// Bench for moore_pattern_tx: table of directed sends plus hand-written abort, reset,
// back-to-back and start/abort priority sequences; a 1101 detector model watches the stream.
module tb_moore_pattern_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic [3:0] repeat_cnt = 4'h0;
  logic       abort = 1'b0;
  logic       x, x_valid, busy, done;

  int checks = 0;
  int errors = 0;

  moore_pattern_tx #(.WIDTH(4), .CNT_W(4), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .abort(abort),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pat;
    logic [3:0] rep;
    bit         mid_change;
    int         exp_len;
    int         exp_done;
    int         exp_det;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // start pulse at edge n, then sample each following cycle at the negedge until busy drops
  task automatic run_vec(input vec_t v, input string tag);
    int nvalid = 0, done_at = -1, done_pulses = 0, busy_cycles = 0;
    int bit_err = 0, idle_err = 0, det = 0, k;
    logic [3:0] win = 4'b0000;
    bit finished = 0;
    @(negedge clk);
    pattern = v.pat; repeat_cnt = v.rep; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!finished && k <= 200) begin
      if (x_valid) begin
        if (x !== v.pat[3 - (nvalid % 4)]) bit_err++;
        win = {win[2:0], x};
        nvalid++;
        if (nvalid >= 4 && win == 4'b1101) det++;
      end else if (x !== 1'b0) idle_err++;
      if (done) begin done_pulses++; done_at = k; end
      if (busy) busy_cycles++;
      else finished = 1;
      if (v.mid_change && k == 2) begin pattern = 4'b0000; start = 1'b1; end
      if (k == 3) start = 1'b0;
      if (!finished) begin @(negedge clk); k++; end
    end
    check({tag, " timeout"}, int'(finished), 1);
    check({tag, " valid_len"}, nvalid, v.exp_len);
    check({tag, " bit_errs"}, bit_err, 0);
    check({tag, " idle_level_errs"}, idle_err, 0);
    check({tag, " done_cycle"}, done_at, v.exp_done);
    check({tag, " done_pulses"}, done_pulses, 1);
    check({tag, " busy_cycles"}, busy_cycles, v.exp_done);
    check({tag, " det_1101"}, det, v.exp_det);
  endtask

  initial begin
    //            pat      rep   mid  len done det
    vecs[0] = '{4'b1101, 4'h0, 1'b0,  4,  5, 1};
    vecs[1] = '{4'b1101, 4'h1, 1'b0,  8,  9, 2};
    vecs[2] = '{4'b1010, 4'hF, 1'b0, 64, 65, 0};
    vecs[3] = '{4'b1111, 4'h2, 1'b0, 12, 13, 0};
    vecs[4] = '{4'b0001, 4'h1, 1'b0,  8,  9, 0};
    vecs[5] = '{4'b1101, 4'h0, 1'b1,  4,  5, 1};
    vecs[6] = '{4'b1101, 4'h3, 1'b0, 16, 17, 4};

    #2;
    check("rst x", int'(x), 0);
    check("rst x_valid", int'(x_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort during the 3rd bit: cycle 3 sampled, abort seen at the edge ending cycle 3
    @(negedge clk);
    pattern = 4'b1101; repeat_cnt = 4'h0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort bit3 valid", int'(x_valid), 1);
    check("abort bit3 x", int'(x), 0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort x_valid", int'(x_valid), 0);
    check("abort busy", int'(busy), 0);
    begin
      int dcount = 0;
      for (int j = 0; j < 6; j++) begin
        if (done) dcount++;
        @(negedge clk);
      end
      check("abort no_done", dcount, 0);
    end
    run_vec(vecs[0], "post_abort");

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start+abort busy", int'(busy), 0);
    check("start+abort x_valid", int'(x_valid), 0);

    // async reset mid-stream, between clock edges
    @(negedge clk);
    pattern = 4'b1111; repeat_cnt = 4'h3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("pre_reset busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("async rst x", int'(x), 0);
    check("async rst x_valid", int'(x_valid), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst done", int'(done), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("post_reset busy", int'(busy), 0);

    // start held high: DONE ignores it, next stream begins after one idle cycle
    @(negedge clk);
    pattern = 4'b1101; repeat_cnt = 4'h0; start = 1'b1;
    begin
      logic [7:0] vbits, dbits, bbits;
      vbits = '0; dbits = '0; bbits = '0;
      for (int j = 1; j <= 8; j++) begin
        @(negedge clk);
        vbits[j-1] = x_valid; dbits[j-1] = done; bbits[j-1] = busy;
      end
      start = 1'b0;
      check("b2b valid_map", int'(vbits), 8'b1100_1111);
      check("b2b done_map",  int'(dbits), 8'b0001_0000);
      check("b2b busy_map",  int'(bbits), 8'b1101_1111);
    end
    begin
      int guard = 0;
      while (busy && guard < 50) begin @(negedge clk); guard++; end
      check("b2b drain", int'(busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
